// File: rtl/dac_stream_pkg.sv
// Shared state type, default parameter values and divider width for the DAC code streamer.
package dac_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIV_W          = 16;
  localparam int DEF_DATA_W     = 10;
  localparam int DEF_NCH        = 2;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_RESET_CODE = 0;
  localparam int DEF_STEP       = 1;

endpackage

// File: rtl/dac_stream_fifo.sv
// Sample FIFO for the DAC code streamer: power-of-two depth, combinational read of the head entry.
module dac_stream_fifo
  import dac_stream_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/dac_code_streamer.sv
// Streams queued per-channel codes to DAC inputs at a programmable tick rate.
// Optional build macro DAC_SLEW_LIMIT_EN: codes walk toward their targets by at most STEP per tick.
module dac_code_streamer
  import dac_stream_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                NCH        = DEF_NCH,
  parameter int                DEPTH      = DEF_DEPTH,
  parameter logic [DATA_W-1:0] RESET_CODE = DATA_W'(DEF_RESET_CODE),
  parameter int                STEP       = DEF_STEP,
  localparam int               CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int               LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CH_W-1:0]       in_ch,
  input  logic                  clr_underrun,
  output logic [NCH*DATA_W-1:0] dac_d,
  output logic                  dac_upd,
  output logic                  underrun,
  output logic [LVL_W-1:0]      level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("dac_code_streamer: DEPTH must be a power of two >= 2");
  end
  if (STEP < 1) begin : g_step_check
    $error("dac_code_streamer: STEP must be >= 1");
  end

  state_t            state;
  state_t            state_next;
  logic              tick;
  logic [DIV_W-1:0]  cnt;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic [DATA_W-1:0] pop_data;
  logic [CH_W-1:0]   pop_ch;
  logic [DATA_W-1:0] code      [NCH];
  logic [DATA_W-1:0] code_next [NCH];
  logic              upd_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick       = 1'b0;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        tick = (cnt == div);
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A lowered div below the running count lets the counter roll over 16 bits before the next tick.
  always_ff @(posedge clk) begin
    if (reset || state != RUN || tick) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  dac_stream_fifo #(
    .WIDTH(DATA_W + CH_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (in_valid),
    .pop  (tick),
    .wdata({in_ch, in_data}),
    .rdata({pop_ch, pop_data}),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign in_ready = !full;
  assign pop_ok   = tick && !empty;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  logic [DATA_W-1:0] target      [NCH];
  logic [DATA_W-1:0] target_next [NCH];

  // The pop lands in the target first, so the same tick already steps toward the new value.
  always_comb begin
    upd_next = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      target_next[k] = target[k];
      code_next[k]   = code[k];
      if (pop_ok && int'(pop_ch) == k) target_next[k] = pop_data;
      if (tick) begin
        if (target_next[k] > code[k])
          code_next[k] = ((target_next[k] - code[k]) > STEP_V) ? code[k] + STEP_V : target_next[k];
        else if (target_next[k] < code[k])
          code_next[k] = ((code[k] - target_next[k]) > STEP_V) ? code[k] - STEP_V : target_next[k];
      end
      if (code_next[k] != code[k]) upd_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) target[k] <= RESET_CODE;
      else       target[k] <= target_next[k];
    end
  end
`else
  // Channel numbers at or above NCH match no channel, so such samples are dropped.
  always_comb begin
    upd_next = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      code_next[k] = code[k];
      if (pop_ok && int'(pop_ch) == k) begin
        code_next[k] = pop_data;
        if (pop_data != code[k]) upd_next = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) code[k] <= RESET_CODE;
      dac_upd <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) code[k] <= code_next[k];
      dac_upd <= upd_next;
    end
  end

  // Setting wins over clearing when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                underrun <= 1'b0;
    else if (tick && empty)   underrun <= 1'b1;
    else if (clr_underrun)    underrun <= 1'b0;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign dac_d[k*DATA_W +: DATA_W] = code[k];
  end

endmodule

// File: tb/tb_dac_code_streamer.sv
// Directed, table-driven bench for dac_code_streamer (default build, three channels, nonzero reset code).
module tb_dac_code_streamer;

  localparam logic [9:0] RC = 10'h011;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] div;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic [1:0]  in_ch;
  logic        clr_underrun;
  logic [29:0] dac_d;
  logic        dac_upd;
  logic        underrun;
  logic [3:0]  level;

  int n_vectors = 0;
  int n_checks = 0;
  int n_miscompares = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        vld;
    logic [9:0]  data;
    logic [1:0]  ch;
    logic        clr;
    logic [9:0]  e0;
    logic [9:0]  e1;
    logic [9:0]  e2;
    logic        eupd;
    logic        eund;
    logic [3:0]  elvl;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  dac_code_streamer #(
    .DATA_W(10),
    .NCH(3),
    .DEPTH(8),
    .RESET_CODE(RC),
    .STEP(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .div         (div),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ch       (in_ch),
    .clr_underrun(clr_underrun),
    .dac_d       (dac_d),
    .dac_upd     (dac_upd),
    .underrun    (underrun),
    .level       (level)
  );

  always #5 clk = ~clk;

  function automatic void add(string name, logic rst, logic e, logic [15:0] d, logic vld,
                              logic [9:0] data, logic [1:0] ch, logic clr,
                              logic [9:0] e0, logic [9:0] e1, logic [9:0] e2,
                              logic eupd, logic eund, logic [3:0] elvl, logic erdy);
    vec_t v;
    v.name = name; v.rst = rst; v.en = e; v.div = d; v.vld = vld;
    v.data = data; v.ch = ch; v.clr = clr;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.eupd = eupd; v.eund = eund; v.elvl = elvl; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  // Inputs are held across one rising edge; outputs are then sampled 1 time unit later.
  task automatic applyStimulus(logic rst, logic e, logic [15:0] d, logic vld,
                               logic [9:0] data, logic [1:0] ch, logic clr);
    reset = rst; en = e; div = d; in_valid = vld;
    in_data = data; in_ch = ch; clr_underrun = clr;
    @(posedge clk);
    #1;
    n_vectors++;
  endtask

  task automatic checkOutput(string what, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; div = '0; in_valid = 1'b0;
    in_data = '0; in_ch = '0; clr_underrun = 1'b0;

    // A: single sample at div=4, then an empty tick sets underrun, then clear.
    add("A_rst", 1,0,0,0,0,0,0,       RC,RC,RC,0,0,0,1);
    add("A_push",0,1,4,1,10'h3FA,0,0, RC,RC,RC,0,0,1,1);
    for (int i = 0; i < 4; i++)
      add($sformatf("A_wait%0d", i), 0,1,4,0,0,0,0, RC,RC,RC,0,0,1,1);
    add("A_tick",0,1,4,0,0,0,0,       10'h3FA,RC,RC,1,0,0,1);
    for (int i = 0; i < 4; i++)
      add($sformatf("A_hold%0d", i), 0,1,4,0,0,0,0, 10'h3FA,RC,RC,0,0,0,1);
    add("A_under",0,1,4,0,0,0,0,      10'h3FA,RC,RC,0,1,0,1);
    add("A_clr", 0,0,4,0,0,0,1,       10'h3FA,RC,RC,0,0,0,1);

    // B: six samples alternating ch0/ch1 drained at div=0.
    add("B_rst", 1,0,0,0,0,0,0,       RC,RC,RC,0,0,0,1);
    for (int i = 0; i < 6; i++)
      add($sformatf("B_push%0d", i), 0,0,0,1,10'h3FA + 10'(i),2'(i % 2),0,
          RC,RC,RC,0,0,4'(i + 1),1);
    add("B_run", 0,1,0,0,0,0,0,       RC,RC,RC,0,0,6,1);
    add("B_pop0",0,1,0,0,0,0,0,       10'h3FA,RC,RC,1,0,5,1);
    add("B_pop1",0,1,0,0,0,0,0,       10'h3FA,10'h3FB,RC,1,0,4,1);
    add("B_pop2",0,1,0,0,0,0,0,       10'h3FC,10'h3FB,RC,1,0,3,1);
    add("B_pop3",0,1,0,0,0,0,0,       10'h3FC,10'h3FD,RC,1,0,2,1);
    add("B_pop4",0,1,0,0,0,0,0,       10'h3FE,10'h3FD,RC,1,0,1,1);
    add("B_pop5",0,1,0,0,0,0,0,       10'h3FE,10'h3FF,RC,1,0,0,1);
    add("B_under",0,1,0,0,0,0,0,      10'h3FE,10'h3FF,RC,0,1,0,1);
    add("B_setclr",0,1,0,0,0,0,1,     10'h3FE,10'h3FF,RC,0,1,0,1);
    add("B_stop",0,0,0,0,0,0,0,       10'h3FE,10'h3FF,RC,0,1,0,1);
    add("B_clr", 0,0,0,0,0,0,1,       10'h3FE,10'h3FF,RC,0,0,0,1);
    add("B_same",0,0,0,1,10'h3FE,0,0, 10'h3FE,10'h3FF,RC,0,0,1,1);
    add("B_run2",0,1,0,0,0,0,0,       10'h3FE,10'h3FF,RC,0,0,1,1);
    add("B_noupd",0,1,0,0,0,0,0,      10'h3FE,10'h3FF,RC,0,0,0,1);
    add("B_under2",0,0,0,0,0,0,0,     10'h3FE,10'h3FF,RC,0,1,0,1);

    // C: fill to full while idle, blocked push during the first pop, out-of-range channel, reset mid-stream.
    add("C_rst", 1,0,0,0,0,0,0,       RC,RC,RC,0,0,0,1);
    add("C_push0",0,0,0,1,10'h100,3,0, RC,RC,RC,0,0,1,1);
    add("C_push1",0,0,0,1,10'h2AA,2,0, RC,RC,RC,0,0,2,1);
    for (int i = 0; i < 6; i++)
      add($sformatf("C_push%0d", i + 2), 0,0,0,1,10'h101 + 10'(i),2'(i % 2),0,
          RC,RC,RC,0,0,4'(i + 3),(i < 5) ? 1'b1 : 1'b0);
    add("C_push9",0,0,0,1,10'h3EE,0,0, RC,RC,RC,0,0,8,0);
    add("C_run", 0,1,1,0,0,0,0,       RC,RC,RC,0,0,8,0);
    add("C_cnt", 0,1,1,0,0,0,0,       RC,RC,RC,0,0,8,0);
    add("C_popx",0,1,1,1,10'h3EE,0,0, RC,RC,RC,0,0,7,1);
    add("C_cnt2",0,1,1,0,0,0,0,       RC,RC,RC,0,0,7,1);
    add("C_pop2",0,1,1,0,0,0,0,       RC,RC,10'h2AA,1,0,6,1);
    add("C_cnt3",0,1,1,0,0,0,0,       RC,RC,10'h2AA,0,0,6,1);
    add("C_pop0",0,1,1,0,0,0,0,       10'h101,RC,10'h2AA,1,0,5,1);
    add("C_cnt4",0,1,1,0,0,0,0,       10'h101,RC,10'h2AA,0,0,5,1);
    add("C_rstm",1,1,1,1,10'h3EE,0,1, RC,RC,RC,0,0,0,1);
    add("C_idle",0,0,1,0,0,0,0,       RC,RC,RC,0,0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].div, vecs[i].vld,
                    vecs[i].data, vecs[i].ch, vecs[i].clr);
      checkOutput({vecs[i].name, ".d0"},  16'(dac_d[9:0]),   16'(vecs[i].e0));
      checkOutput({vecs[i].name, ".d1"},  16'(dac_d[19:10]), 16'(vecs[i].e1));
      checkOutput({vecs[i].name, ".d2"},  16'(dac_d[29:20]), 16'(vecs[i].e2));
      checkOutput({vecs[i].name, ".upd"}, 16'(dac_upd),      16'(vecs[i].eupd));
      checkOutput({vecs[i].name, ".und"}, 16'(underrun),     16'(vecs[i].eund));
      checkOutput({vecs[i].name, ".lvl"}, 16'(level),        16'(vecs[i].elvl));
      checkOutput({vecs[i].name, ".rdy"}, 16'(in_ready),     16'(vecs[i].erdy));
    end

    // D: lowering div below the running count must not produce an early tick.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 10'h0AB, 1, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      checkOutput($sformatf("D_notick%0d.lvl", i), 16'(level), 16'd1);
      checkOutput($sformatf("D_notick%0d.upd", i), 16'(dac_upd), 16'd0);
    end
    checkOutput("D_hold.d1", 16'(dac_d[19:10]), 16'(RC));
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("D_rst.lvl", 16'(level), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/dac_code_streamer.md
DAC_CODE_STREAMER -- requirements
Module: dac_code_streamer

Interface
REQ-001 Parameter DATA_W, default 10, DAC code width per channel.
REQ-002 Parameter NCH, default 2, number of DAC channels; CH_W = max(1, clog2(NCH)).
REQ-003 Parameter DEPTH, default 8, sample FIFO depth; power of two, >= 2.
REQ-004 Parameter RESET_CODE, default 0, per-channel output code after reset.
REQ-005 Parameter STEP, default 1, max code change per tick; used only with DAC_SLEW_LIMIT_EN.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 en  in  1  streaming enable.
REQ-009 div  in  16  update period minus one, in clk cycles.
REQ-010 in_valid  in  1  sample offered.
REQ-011 in_ready  out  1  FIFO can accept a sample.
REQ-012 in_data  in  DATA_W  sample code.
REQ-013 in_ch  in  CH_W  destination channel.
REQ-014 clr_underrun  in  1  clears the underrun flag.
REQ-015 dac_d  out  NCH*DATA_W  channel codes; channel k at bits [k*DATA_W +: DATA_W]; feeds avsddac D inputs.
REQ-016 dac_upd  out  1  one-cycle pulse, high in the cycle dac_d changes.
REQ-017 underrun  out  1  sticky: tick occurred with FIFO empty.
REQ-018 level  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 States IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; dac_d holds its value in IDLE.
REQ-020 Tick counter runs in RUN only: counts 0..div, tick when count==div, then wraps to 0; counter forced to 0 in IDLE; div=0 gives a tick every cycle.
REQ-021 div sampled continuously; if div is lowered below the current count, the counter wraps at 16 bits (no early tick).
REQ-022 in_ready = !full; push when in_valid && in_ready, in any state; in_ready stays low when full, even if a pop occurs the same cycle.
REQ-023 On tick with FIFO non-empty: pop one entry; the target for entry in_ch becomes the entry's in_data; pop with in_ch >= NCH discards the sample.
REQ-024 On tick with FIFO empty: no pop, underrun set to 1 next cycle, outputs hold.
REQ-025 clr_underrun clears underrun next cycle; a simultaneous set takes priority over clear.
REQ-026 Without slew limiting, dac_d for the addressed channel equals the popped code 1 cycle after the tick; dac_upd pulses in that cycle only if the code differs from the previous one.
REQ-027 level updates 1 cycle after push/pop; simultaneous push and pop leaves level unchanged.
REQ-028 Pointer wrap at DEPTH is silent; FIFO data order is strictly preserved.

Reset
REQ-029 Reset results: state IDLE, counter 0, FIFO empty (level 0, in_ready 1), all channel codes and targets = RESET_CODE, dac_upd 0, underrun 0.
REQ-030 Reset during RUN discards FIFO contents and any pending tick; reset dominates all other inputs.

Configuration
REQ-031 Macro DAC_SLEW_LIMIT_EN: when defined, each tick in RUN moves every channel's dac_d toward its target by min(STEP, |target-dac_d|), applied 1 cycle after the tick; the pop in the same tick updates the target before the step; dac_upd pulses if any channel changed.
REQ-032 When DAC_SLEW_LIMIT_EN is undefined, STEP is ignored and REQ-026 applies.

Structure
REQ-033 Package dac_stream_pkg holds the state enum (IDLE, RUN), the default parameter constants, and the div width constant (16).
REQ-034 Sub-module dac_stream_fifo (DATA_W+CH_W wide, DEPTH deep, push/pop/full/empty/level) is instantiated once.

Verification
REQ-035 Reset, then en=1, div=4, push 0x3FA ch0: dac_d[9:0]=0x3FA 1 cycle after the first tick (cycle 5 of RUN), dac_upd pulses once.
REQ-036 Push 0x3FA..0x3FF alternating ch0/ch1, div=0: one channel update per cycle in push order, then underrun=1 on the next tick.
REQ-037 Fill 8 entries with en=0: in_ready=0, level=8, 9th push ignored; after en=1 pops, in_ready returns high 1 cycle after the first pop.
REQ-038 DAC_SLEW_LIMIT_EN, STEP=4, target 0x010 from 0x000, div=0: dac_d steps 4,8,12,16 on successive cycles, then holds with dac_upd low.
REQ-039 Assert reset mid-stream with level=5: next cycle level=0, dac_d=RESET_CODE, underrun=0; clr_underrun and an underrun tick in the same cycle leave underrun=1.
